// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution MCU controller and its host sequencer.
//   phase_t   : MCU phase code {eop,sop}. The sequencer's FSM state register holds
//               this code directly, so the state value is also the phase output.
//   N_DEFAULT : default kernel row count. The MCU owns N+2 banks.
//   clog2     : ceiling log2, used to size the bank counters.
package conv_pkg;

    localparam int N_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_PROC = 2'b01,
        ST_OUT  = 2'b10,
        ST_IDLE = 2'b11
    } phase_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mcu_seq.sv
// mcu_seq: host-side sequencer for the convolution MCU. One i_start runs a whole image.
// The image starts with N+1 priming bank loads. Each further block loads one bank. Every
// block ends with a process phase and an output phase.
//
// Ports
//   clk, rst              : clock; asynchronous active-low reset
//   i_start               : job start, sampled in IDLE only
//   i_ncols, i_nblk       : words per bank and blocks per image, latched at start
//   i_load_vld/o_load_rdy : host load stream handshake, active in LOAD
//   o_out_vld/i_out_rdy   : consumer output stream handshake, active in OUT
//   o_sop, o_eop          : MCU phase code {eop,sop}
//   o_chblk               : one-cycle bank-advance pulse, driven from a flop
//   o_busy, o_done        : busy outside IDLE; done pulses in the first IDLE cycle
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for i_start
// ST_LOAD | accepting bank words; chblk bubble after each full bank
// ST_PROC | datapath drains for ncols+PROC_LAT cycles
// ST_OUT  | presenting output words; chblk bubble after the last word
module mcu_seq
    import conv_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int COL_W    = 10,
    parameter int PROC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [COL_W-1:0] i_ncols,
    input  logic [7:0]       i_nblk,
    input  logic             i_load_vld,
    output logic             o_load_rdy,
    output logic             o_out_vld,
    input  logic             i_out_rdy,
    output logic             o_sop,
    output logic             o_eop,
    output logic             o_chblk,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BW = clog2(N + 2);
    localparam int PW = COL_W + 1;
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

    phase_t           state, state_nx;
    logic [COL_W-1:0] ncols_r, ncols_nx;
    logic [7:0]       nblk_r, nblk_nx;
    logic [COL_W-1:0] col_cnt, col_nx;
    logic [BW-1:0]    bank_cnt, bank_nx;
    logic [BW-1:0]    banks_to_load, btl_nx;
    logic [7:0]       blk_cnt, blk_nx;
    logic [PW-1:0]    proc_cnt, proc_nx;
    logic             chblk_nx;
    logic             done_nx;
    logic             last_col;

    assign last_col = (col_cnt == ncols_r - COL_ONE);
    assign {o_eop, o_sop} = state;

    always_comb begin
        state_nx = state;
        ncols_nx = ncols_r;
        nblk_nx  = nblk_r;
        col_nx   = col_cnt;
        bank_nx  = bank_cnt;
        btl_nx   = banks_to_load;
        blk_nx   = blk_cnt;
        proc_nx  = proc_cnt;
        chblk_nx = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    ncols_nx = i_ncols;
                    nblk_nx  = i_nblk;
                    blk_nx   = '0;
                    btl_nx   = BW'(N + 1);
                    // An empty image finishes on the spot, without leaving IDLE.
                    if (i_ncols == '0 || i_nblk == '0)
                        done_nx = 1'b1;
                    else
                        state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (o_chblk) begin
                    if (bank_cnt == banks_to_load) begin
                        state_nx = ST_PROC;
                        bank_nx  = '0;
                        // The down-counter expires after exactly ncols+PROC_LAT cycles.
                        proc_nx  = PW'(ncols_r) + PW'(PROC_LAT - 1);
                    end
                end else if (i_load_vld && o_load_rdy) begin
                    if (last_col) begin
                        col_nx   = '0;
                        bank_nx  = bank_cnt + BW'(1);
                        chblk_nx = 1'b1;
                    end else begin
                        col_nx = col_cnt + COL_ONE;
                    end
                end
            end
            ST_PROC: begin
                if (proc_cnt == '0)
                    state_nx = ST_OUT;
                else
                    proc_nx = proc_cnt - PW'(1);
            end
            ST_OUT: begin
                if (o_chblk) begin
                    if (blk_cnt == nblk_r) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ST_LOAD;
                        btl_nx   = BW'(1);
                    end
                end else if (i_out_rdy && o_out_vld) begin
                    if (last_col) begin
                        col_nx   = '0;
                        blk_nx   = blk_cnt + 8'd1;
                        chblk_nx = 1'b1;
                    end else begin
                        col_nx = col_cnt + COL_ONE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs are derived from the next state and the next chblk value, so
    // they are registered together with the state and line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ncols_r       <= '0;
            nblk_r        <= '0;
            col_cnt       <= '0;
            bank_cnt      <= '0;
            banks_to_load <= '0;
            blk_cnt       <= '0;
            proc_cnt      <= '0;
            o_chblk       <= 1'b0;
            o_load_rdy    <= 1'b0;
            o_out_vld     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_nx;
            ncols_r       <= ncols_nx;
            nblk_r        <= nblk_nx;
            col_cnt       <= col_nx;
            bank_cnt      <= bank_nx;
            banks_to_load <= btl_nx;
            blk_cnt       <= blk_nx;
            proc_cnt      <= proc_nx;
            o_chblk       <= chblk_nx;
            o_load_rdy    <= (state_nx == ST_LOAD) && !chblk_nx;
            o_out_vld     <= (state_nx == ST_OUT) && !chblk_nx;
            o_busy        <= (state_nx != ST_IDLE);
            o_done        <= done_nx;
        end
    end

endmodule

// File: tb/tb_mcu_seq.sv
module tb_mcu_seq;

    localparam int N     = 2;
    localparam int COL_W = 10;
    localparam int LAT   = 4;

    localparam logic [1:0] P_LOAD = 2'b00;
    localparam logic [1:0] P_PROC = 2'b01;
    localparam logic [1:0] P_OUT  = 2'b10;
    localparam logic [1:0] P_IDLE = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic [COL_W-1:0] i_ncols = '0;
    logic [7:0]       i_nblk = '0;
    logic             i_load_vld = 1'b0;
    logic             o_load_rdy;
    logic             o_out_vld;
    logic             i_out_rdy = 1'b0;
    logic             o_sop, o_eop, o_chblk, o_busy, o_done;

    always #5 clk = ~clk;

    mcu_seq #(.N(N), .COL_W(COL_W), .PROC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_ncols(i_ncols), .i_nblk(i_nblk),
        .i_load_vld(i_load_vld), .o_load_rdy(o_load_rdy), .o_out_vld(o_out_vld),
        .i_out_rdy(i_out_rdy), .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk),
        .o_busy(o_busy), .o_done(o_done)
    );

    int checks   = 0;
    int failures = 0;
    int cur_cyc  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cur_cyc, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_phase"}, int'({o_eop, o_sop}), int'(P_IDLE));
        chk({tag, "_chblk"}, int'(o_chblk), 0);
        chk({tag, "_load_rdy"}, int'(o_load_rdy), 0);
        chk({tag, "_out_vld"}, int'(o_out_vld), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
    endtask

    // Reference model. The job is a list of segments {phase, amount}. A LOAD or OUT
    // segment ends after its amount of chblk bubbles. A PROC segment lasts amount cycles.
    // A chblk bubble follows the cycle that carries the ncols-th accepted word.
    task automatic run_job(input int ncols, input int nblk, input int vld_mode,
                           input int rdy_mode, input bit sio, output int cycles);
        logic [1:0] exp_ph[$];
        int         exp_n[$];
        logic [1:0] ep;
        int  si, seg_cnt, seg_chb, acc_cnt, cyc, hold_left;
        bit  pend, next_pend, finished, sio_done, vld, rdy, acc, advance;
        if (ncols > 0 && nblk > 0) begin
            for (int b = 0; b < nblk; b++) begin
                exp_ph.push_back(P_LOAD); exp_n.push_back(b == 0 ? N + 1 : 1);
                exp_ph.push_back(P_PROC); exp_n.push_back(ncols + LAT);
                exp_ph.push_back(P_OUT);  exp_n.push_back(1);
            end
        end
        si = 0; seg_cnt = 0; seg_chb = 0; acc_cnt = 0; cyc = 0; hold_left = 10;
        pend = 1'b0; finished = 1'b0; sio_done = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_ncols = COL_W'(ncols); i_nblk = 8'(nblk);
        i_load_vld = 1'b0; i_out_rdy = 1'b0;
        while (!finished && cyc < 5000) begin
            @(negedge clk);
            cyc++; cur_cyc = cyc;
            i_start = 1'b0;
            ep = (si < exp_ph.size()) ? exp_ph[si] : P_IDLE;
            chk("phase", int'({o_eop, o_sop}), int'(ep));
            chk("chblk", int'(o_chblk), int'(pend));
            chk("load_rdy", int'(o_load_rdy), int'(ep == P_LOAD && !pend));
            chk("out_vld", int'(o_out_vld), int'(ep == P_OUT && !pend));
            chk("busy", int'(o_busy), int'(ep != P_IDLE));
            chk("done", int'(o_done), int'(ep == P_IDLE));
            if (ep == P_IDLE) begin
                finished = 1'b1;
            end else begin
                case (vld_mode)
                    0: vld = 1'b1;
                    1: vld = (cyc % 2) == 1;
                    default: vld = ($urandom_range(0, 3) != 0);
                endcase
                case (rdy_mode)
                    0: rdy = 1'b1;
                    3: begin
                        rdy = !(ep == P_OUT && hold_left > 0);
                        if (ep == P_OUT && hold_left > 0) hold_left--;
                    end
                    default: rdy = ($urandom_range(0, 3) != 0);
                endcase
                i_load_vld = vld;
                i_out_rdy  = rdy;
                if (sio && !sio_done && ep == P_OUT) begin
                    i_start = 1'b1; i_ncols = COL_W'(7); i_nblk = 8'd9;
                    sio_done = 1'b1;
                end
                acc = (ep == P_LOAD && !pend && vld) || (ep == P_OUT && !pend && rdy);
                next_pend = 1'b0;
                if (acc) begin
                    acc_cnt++;
                    if (acc_cnt == ncols) begin
                        acc_cnt = 0;
                        next_pend = 1'b1;
                    end
                end
                seg_cnt++;
                if (pend) seg_chb++;
                advance = (ep == P_PROC) ? (seg_cnt == exp_n[si])
                                         : (pend && seg_chb == exp_n[si]);
                if (advance) begin
                    si++; seg_cnt = 0; seg_chb = 0;
                end
                pend = next_pend;
            end
        end
        chk("job_finished", int'(finished), 1);
        cycles = cyc;
        @(negedge clk);
        i_start = 1'b0;
        chk("done_single_pulse", int'(o_done), 0);
        chk("idle_after_job", int'({o_eop, o_sop}), int'(P_IDLE));
        i_load_vld = 1'b0; i_out_rdy = 1'b0;
    endtask

    typedef struct {
        int ncols;
        int nblk;
        int vld_mode;
        int rdy_mode;
        bit start_in_out;
        int exp_cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c;
        int proc_seen;

        // Cycle counts are measured from the start edge to the first IDLE (done) cycle.
        vecs[0] = '{4, 2, 0, 0, 1'b0, 47};
        vecs[1] = '{4, 2, 1, 0, 1'b0, -1};
        vecs[2] = '{4, 2, 0, 3, 1'b0, 57};
        vecs[3] = '{0, 3, 0, 0, 1'b0, 1};
        vecs[4] = '{5, 0, 0, 0, 1'b0, 1};
        vecs[5] = '{4, 2, 0, 0, 1'b1, 47};
        vecs[6] = '{1, 1, 0, 0, 1'b0, 14};
        vecs[7] = '{3, 3, 0, 0, 1'b0, 54};

        #2 rst = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].ncols, vecs[i].nblk, vecs[i].vld_mode, vecs[i].rdy_mode,
                    vecs[i].start_in_out, c);
            if (vecs[i].exp_cycles >= 0) chk("job_cycles", c, vecs[i].exp_cycles);
        end

        // Reset in the middle of PROC, then a full fresh job with all priming loads.
        @(negedge clk);
        i_start = 1'b1; i_ncols = COL_W'(4); i_nblk = 8'd2;
        i_load_vld = 1'b1; i_out_rdy = 1'b1;
        proc_seen = 0;
        for (int k = 0; k < 100 && proc_seen < 2; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if ({o_eop, o_sop} == P_PROC) proc_seen++;
        end
        chk("reached_proc", proc_seen, 2);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("mid_proc_reset");
        repeat (2) @(negedge clk);
        chk("no_done_in_reset", int'(o_done), 0);
        rst = 1'b1;
        i_load_vld = 1'b0; i_out_rdy = 1'b0;
        run_job(4, 2, 0, 0, 1'b0, c);
        chk("job_cycles_after_reset", c, 47);

        for (int r = 0; r < 8; r++) begin
            run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 2, 2, 1'b0, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
